// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the bit_serializer parallel-to-serial stage.
package bit_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_t;

    localparam logic IDLE_BIT_DEFAULT = 1'b1;

    // Widest word the parity helper covers; narrower words are zero-extended.
    localparam int unsigned PARITY_MAX_W = 64;

    // Even-parity bit: makes the total number of ones in word+parity even.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Word load handshake between an upstream producer and bit_serializer.
interface bit_serializer_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;

    modport master (
        output load_data,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  load_data,
        input  load_valid,
        output load_ready
    );
endinterface

// File: rtl/bit_serializer_hold.sv
// One-entry holding register in front of the shift stage.
module bit_serializer_hold #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    input  logic             pull,
    output logic [WIDTH-1:0] hold_data,
    output logic             hold_full,
    output logic             load_ready
);

    logic accept;

    // Ready depends on registered state only; a pull frees the slot this cycle.
    assign load_ready = ~hold_full | pull;
    assign accept     = load_valid & load_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else begin
            if (accept) begin
                hold_data <= load_data;
            end
            hold_full <= accept | (hold_full & ~pull);
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with gapless back-to-back frames.
// Optional trailing even-parity bit when BIT_SERIALIZER_PARITY_EN is defined.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_BIT  = IDLE_BIT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    bit_serializer_if.slave  ld,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    ser_state_t       state, state_n;
    logic [WIDTH-1:0] shift_reg, shift_n;
    logic [CNT_W-1:0] bit_cnt, cnt_n;
    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic             load_ready;
    logic             last;
    logic             pull;
    logic             out_bit;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             parity_reg, parity_n;
`endif

    bit_serializer_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk        (clk),
        .reset      (reset),
        .load_data  (ld.load_data),
        .load_valid (ld.load_valid),
        .pull       (pull),
        .hold_data  (hold_data),
        .hold_full  (hold_full),
        .load_ready (load_ready)
    );

    assign ld.load_ready = load_ready;

`ifdef BIT_SERIALIZER_PARITY_EN
    assign last = (state == PARITY);
`else
    assign last = (state == SHIFT) && (bit_cnt == CNT_LAST);
`endif

    assign pull    = hold_full & ((state == IDLE) | last);
    assign out_bit = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];

    // State, shift and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            shift_reg <= shift_n;
            bit_cnt   <= cnt_n;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_reg <= parity_n;
`endif
        end
    end

    // Next-state: a pull always wins, so a waiting word follows the last bit directly
    always_comb begin
        state_n = state;
        shift_n = shift_reg;
        cnt_n   = bit_cnt;
`ifdef BIT_SERIALIZER_PARITY_EN
        parity_n = parity_reg;
`endif
        if (pull) begin
            state_n = SHIFT;
            shift_n = hold_data;
            cnt_n   = '0;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_n = even_parity(PARITY_MAX_W'(hold_data));
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = IDLE;
                end
                SHIFT: begin
                    if (bit_cnt == CNT_LAST) begin
`ifdef BIT_SERIALIZER_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = IDLE;
`endif
                    end else begin
                        cnt_n   = bit_cnt + CNT_W'(1);
                        shift_n = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                                            : {1'b0, shift_reg[WIDTH-1:1]};
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from registered state
    always_comb begin
        ser_out    = IDLE_BIT;
        ser_valid  = 1'b0;
        frame_done = last;
        busy       = (state != IDLE) | hold_full;
        if (state == SHIFT) begin
            ser_out   = out_bit;
            ser_valid = 1'b1;
        end
`ifdef BIT_SERIALIZER_PARITY_EN
        if (state == PARITY) begin
            ser_out   = parity_reg;
            ser_valid = 1'b1;
        end
`endif
    end

endmodule
